// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
// Optional feature macro: FIFO_UART_PARITY_EN (adds an even-parity bit per frame).
package fifo_uart_pkg;

    localparam int DATA_W_DEF       = 8;
    // Frame lengths in bit periods: start + data + stop, optionally + parity.
    localparam int FRAME_BITS_NOPAR = DATA_W_DEF + 2;
    localparam int FRAME_BITS_PAR   = DATA_W_DEF + 3;

`ifdef FIFO_UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_t;

    // Even parity: XOR of all data bits (zero-extension does not change it).
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd6
    } uart_state_t;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// uart_baud_cnt: bit-period counter; bit_tick marks the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_tick
);

    assign bit_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Count clock cycles within a bit, wrapping to zero at the bit boundary
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from an upstream FIFO and sends them as 8N1-style
// UART frames (start, DATA_W bits LSB first, [even parity], stop).
// Optional feature macro: FIFO_UART_PARITY_EN.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_wr,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_state_t       state_r;
    logic [DATA_W-1:0] shift_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic              tx_r;
    logic              busy_r;
    logic              tx_done_r;
`ifdef FIFO_UART_PARITY_EN
    logic              parity_r;
`endif

    logic [CNT_W-1:0]  baud_cnt_s;
    logic              bit_tick_s;
    logic              baud_clear_s;
    logic              rd_accept_s;
    logic              done_next_s;

    // The FIFO gives a simultaneous non-full write priority over our read.
    assign fifo_rd      = (state_r == ST_REQ);
    assign rd_accept_s  = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full);
    // Baud counter only runs while a bit is on the line.
    assign baud_clear_s = (state_r == ST_IDLE) || (state_r == ST_REQ) || (state_r == ST_LOAD);
    // Registered tx_done must be set one cycle ahead of the last stop-bit cycle.
    assign done_next_s  = (state_r == ST_STOP) && (baud_cnt_s == CNT_W'(CLKS_PER_BIT - 2));

    assign tx      = tx_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear_s),
        .cnt      (baud_cnt_s),
        .bit_tick (bit_tick_s)
    );

    // Frame sequencer: state, shift register, bit counter and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            tx_done_r <= done_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_r <= ST_REQ;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (rd_accept_s) begin
                        state_r <= ST_LOAD;
                    end else if (fifo_empty) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_LOAD: begin
                    // Registered FIFO data is valid the cycle after acceptance.
                    shift_r   <= fifo_dout;
`ifdef FIFO_UART_PARITY_EN
                    parity_r  <= even_parity(32'(fifo_dout));
`endif
                    bit_cnt_r <= '0;
                    tx_r      <= 1'b0;
                    state_r   <= ST_START;
                end
                ST_START: begin
                    if (bit_tick_s) begin
                        tx_r    <= shift_r[0];
                        shift_r <= shift_r >> 1'b1;
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick_s) begin
                        if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
                            bit_cnt_r <= '0;
`ifdef FIFO_UART_PARITY_EN
                            tx_r      <= parity_r;
                            state_r   <= ST_PARITY;
`else
                            tx_r      <= 1'b1;
                            state_r   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                            tx_r      <= shift_r[0];
                            shift_r   <= shift_r >> 1'b1;
                        end
                    end
                end
`ifdef FIFO_UART_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick_s) begin
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick_s) begin
                        state_r <= ST_IDLE;
                        // Stay busy across the idle cycle when another byte is waiting.
                        busy_r  <= !fifo_empty;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with CLKS_PER_BIT=4, a
// frame-level reference model and hand-computed frame captures.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [15:0] CAP_A5 = 16'h054A, CAP_5A = 16'h04B4, CAP_00 = 16'h0400,
                            CAP_FF = 16'h05FE, CAP_81 = 16'h0502, CAP_07 = 16'h060E,
                            CAP_03 = 16'h0406;
`else
    localparam int NBITS = 10;
    localparam logic [15:0] CAP_A5 = 16'h034A, CAP_5A = 16'h02B4, CAP_00 = 16'h0200,
                            CAP_FF = 16'h03FE, CAP_81 = 16'h0302, CAP_07 = 16'h020E,
                            CAP_03 = 16'h0206;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic       fifo_full = 1'b0;
    logic       fifo_wr = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd, tx, busy, tx_done;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int rd_cnt = 0;
    int done_cnt = 0;

    // Upstream FIFO storage: bench writes via wp, FIFO pops via rp, model via m_rp.
    logic [7:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    // Reference model: phase 0 idle, 1 request, 2 load, 3 frame at offset m_pos.
    int         m_phase = 0;
    int         m_pos = 0;
    int         m_rp = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_busy = 1'b0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Clock generator
    always #5 clk = ~clk;

    // Line level for bit period idx of a frame carrying byte b
    function automatic logic model_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef FIFO_UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp % 64] = b;
        wp++;
    endtask

    // FIFO behaviour: registered read data, write has priority over read
    always @(posedge clk) begin
        if (fifo_rd === 1'b1 && !fifo_empty && !(fifo_wr && !fifo_full)) begin
            fifo_dout <= mem[rp % 64];
            rp <= rp + 1;
        end
    end

    // Reference model update, one step per clock
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_pos   <= 0;
            m_busy  <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_busy <= !fifo_empty;
                    if (!fifo_empty) m_phase <= 1;
                end
                1: begin
                    if (!fifo_empty && !(fifo_wr && !fifo_full)) begin
                        m_phase <= 2;
                        m_byte  <= mem[m_rp % 64];
                        m_rp    <= m_rp + 1;
                    end else if (fifo_empty) begin
                        m_phase <= 0;
                        m_busy  <= 1'b0;
                    end
                end
                2: begin
                    m_phase <= 3;
                    m_pos   <= 0;
                end
                default: begin
                    if (m_pos == FLEN - 1) begin
                        m_phase <= 0;
                        m_busy  <= !fifo_empty;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("tx", tx, (m_phase == 3) ? model_bit(m_byte, m_pos / CPB) : 1'b1);
            check_bit("busy", busy, m_busy);
            check_bit("fifo_rd", fifo_rd, m_phase == 1);
            check_bit("tx_done", tx_done, (m_phase == 3) && (m_pos == FLEN - 1));
        end
    end

    // Event counters for read strobes and completed frames
    always @(negedge clk) begin
        if (fifo_rd === 1'b1) rd_cnt++;
        if (tx_done === 1'b1) done_cnt++;
    end

    // Capture one frame at mid-bit points; returns length up to and including tx_done
    task automatic measure_frame(input bit at_start, output logic [15:0] cap,
                                 output int len, output bit busy_ok);
        int w;
        cap = 16'h0000;
        len = 0;
        busy_ok = 1'b1;
        w = 0;
        if (!at_start) begin
            @(negedge clk);
            while (tx !== 1'b0 && w < 400) begin
                @(negedge clk);
                w++;
            end
        end
        check_bit("frame_start", tx, 1'b0);
        if (tx !== 1'b0) return;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (k % CPB == 1) cap[k / CPB] = tx;
            if (tx_done === 1'b1) begin
                len = k + 1;
                break;
            end
        end
    endtask

    logic [15:0] cap;
    int          len, gap, rd0, done0, w;
    bit          bok, gap_busy;

    // Directed stimulus
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_tx", tx, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_fifo_rd", fifo_rd, 1'b0);
        check_bit("rst_tx_done", tx_done, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) tick();

        // Single byte 0xA5
        rd0 = rd_cnt;
        push(8'hA5);
        measure_frame(1'b0, cap, len, bok);
        check_val("a5_cap", {16'h0, cap}, {16'h0, CAP_A5});
        check_val("a5_len", len, FLEN);
        check_bit("a5_busy", bok, 1'b1);
        check_val("a5_rd_cycles", rd_cnt - rd0, 1);

        // Non-full write during REQ stalls the read for two cycles
        repeat (5) tick();
        rd0 = rd_cnt;
        done0 = done_cnt;
        push(8'h5A);
        tick();
        fifo_wr = 1'b1;
        tick();
        tick();
        fifo_wr = 1'b0;
        measure_frame(1'b0, cap, len, bok);
        check_val("wr_cap", {16'h0, cap}, {16'h0, CAP_5A});
        repeat (20) tick();
        check_val("wr_rd_cycles", rd_cnt - rd0, 3);
        check_val("wr_frames", done_cnt - done0, 1);

        // Back-to-back bytes 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        measure_frame(1'b0, cap, len, bok);
        check_val("b2b_cap0", {16'h0, cap}, {16'h0, CAP_00});
        gap = 0;
        gap_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) gap_busy = 1'b0;
            if (tx === 1'b0) break;
            gap++;
        end
        check_val("b2b_gap", gap, 3);
        check_bit("b2b_gap_busy", gap_busy, 1'b1);
        measure_frame(1'b1, cap, len, bok);
        check_val("b2b_cap1", {16'h0, cap}, {16'h0, CAP_FF});
        check_bit("b2b_busy", bok, 1'b1);

        // Reset in frame cycle 18 of a 0x3C frame
        repeat (5) tick();
        done0 = done_cnt;
        push(8'h3C);
        w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_bit("rst_frame_start", tx, 1'b0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_bit("abort_tx", tx, 1'b1);
        check_bit("abort_busy", busy, 1'b0);
        rst = 1'b0;
        rd0 = rd_cnt;
        repeat (30) tick();
        check_val("abort_no_done", done_cnt - done0, 0);
        check_val("abort_no_rd", rd_cnt - rd0, 0);

        // Full-FIFO write does not block the read
        fifo_wr = 1'b1;
        fifo_full = 1'b1;
        rd0 = rd_cnt;
        push(8'h81);
        measure_frame(1'b0, cap, len, bok);
        check_val("full_cap", {16'h0, cap}, {16'h0, CAP_81});
        check_val("full_rd_cycles", rd_cnt - rd0, 1);
        fifo_wr = 1'b0;
        fifo_full = 1'b0;

        // Parity-sensitive bytes
        repeat (5) tick();
        push(8'h07);
        push(8'h03);
        measure_frame(1'b0, cap, len, bok);
        check_val("p07_cap", {16'h0, cap}, {16'h0, CAP_07});
        check_val("p07_len", len, FLEN);
        measure_frame(1'b0, cap, len, bok);
        check_val("p03_cap", {16'h0, cap}, {16'h0, CAP_03});

        repeat (10) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit; legal range is >= 2.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the byte width read from the FIFO.
REQ-003 Port clk, input, 1: clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-006 Port fifo_full, input, 1: upstream FIFO full flag.
REQ-007 Port fifo_wr, input, 1: upstream FIFO write strobe, monitored only.
REQ-008 Port fifo_dout, input, DATA_W: upstream FIFO registered read data.
REQ-009 Port fifo_rd, output, 1: read strobe to the FIFO.
REQ-010 Port tx, output, 1: serial line, idle high.
REQ-011 Port busy, output, 1: high whenever the state is not IDLE.
REQ-012 Port tx_done, output, 1: one-cycle pulse in the last cycle of the stop bit.

Function
REQ-013 States SHALL be IDLE, REQ, LOAD, START, DATA, PARITY (only when parity is compiled in) and STOP.
REQ-014 IDLE -> REQ on the next edge when fifo_empty=0; otherwise the block stays in IDLE.
REQ-015 fifo_rd SHALL be 1 exactly while the state is REQ (combinational decode, no other state).
REQ-016 A read is accepted when fifo_rd=1 and fifo_empty=0 and !(fifo_wr=1 and fifo_full=0); the FIFO gives writes priority.
REQ-017 In REQ: if the read is accepted -> LOAD; if fifo_empty=1 -> IDLE; otherwise stay in REQ and retry next cycle.
REQ-018 In LOAD, the shift register SHALL capture fifo_dout (valid one cycle after acceptance) and the state goes to START.
REQ-019 START drives tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
REQ-020 DATA drives DATA_W bits LSB first, each for CLKS_PER_BIT cycles; after the last bit it goes to PARITY or STOP.
REQ-021 STOP drives tx=1 for CLKS_PER_BIT cycles; tx_done=1 in its final cycle; then the state goes to IDLE.
REQ-022 Frame time SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is compiled in.
REQ-023 Back-to-back bytes SHALL have exactly 3 cycles of tx=1 (IDLE, REQ, LOAD) between a stop bit and the next start bit when reads are accepted first time.
REQ-024 The bit counter and baud counter SHALL wrap to 0 at each bit or frame boundary; no counter overflows for any legal parameter.
REQ-025 tx SHALL be registered (glitch-free); it is 1 in IDLE, REQ and LOAD.

Reset
REQ-026 On rst=1: state=IDLE, tx=1, fifo_rd=0, busy=0, tx_done=0, counters=0, shift register=0, all in the next cycle.
REQ-027 Reset mid-frame SHALL abort the frame (the byte is lost) and take tx high on the next edge.
REQ-028 rst has priority over every other condition, including an accepted read in the same cycle.

Configuration
REQ-029 With macro FIFO_UART_PARITY_EN defined, the PARITY state SHALL drive the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-030 Without FIFO_UART_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA goes directly to STOP.

Structure
REQ-031 Package fifo_uart_pkg SHALL hold the state enum typedef, DATA_W default, and frame-length constants (with and without parity).
REQ-032 Sub-module uart_baud_cnt SHALL be instantiated once: a counter of width $clog2(CLKS_PER_BIT), clear input, and a bit_tick pulse at count CLKS_PER_BIT-1.

Verification (CLKS_PER_BIT=4, parity off unless stated)
REQ-033 FIFO holding 0xA5, idle -> fifo_rd for 1 cycle; tx = 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; tx_done at cycle 40 of the frame.
REQ-034 fifo_wr=1 with fifo_full=0 during REQ for 2 cycles -> fifo_rd stays high 3 cycles; one byte is transmitted, not duplicated.
REQ-035 Bytes 0x00 then 0xFF queued -> two frames separated by exactly 3 idle-high cycles; busy stays high throughout.
REQ-036 rst asserted at cycle 18 of a 0x3C frame -> tx=1, busy=0 next cycle; no tx_done; fifo_rd=0 until fifo_empty=0 after reset.
REQ-037 FIFO_UART_PARITY_EN defined, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0.
REQ-038 fifo_wr=1 with fifo_full=1 during REQ -> read accepted that cycle (write blocked), LOAD follows.
